// File: rtl/display_pkg.sv
// rtl/display_pkg.sv - shared constants and helpers for the 4-digit display scanner
package display_pkg;

  localparam int         NUM_DIGITS = 4;
  localparam logic [3:0] DIG0       = 4'b0001;
  localparam logic [3:0] DIG1       = 4'b0010;
  localparam logic [3:0] DIG2       = 4'b0100;
  localparam logic [3:0] DIG3       = 4'b1000;
  localparam logic [3:0] ANODES_OFF = 4'b1111;

  typedef logic [1:0] dig_idx_t;

  function automatic logic [3:0] nibble_sel(input logic [15:0] num, input dig_idx_t idx);
    return num[{idx, 2'b00} +: 4];
  endfunction

  function automatic logic [3:0] dig_onehot(input dig_idx_t idx);
    logic [3:0] sel;
    case (idx)
      2'd0:    sel = DIG0;
      2'd1:    sel = DIG1;
      2'd2:    sel = DIG2;
      default: sel = DIG3;
    endcase
    return sel;
  endfunction

  // Digit idx is a leading zero when it and every more significant nibble are zero.
  function automatic logic lead_zero(input logic [15:0] num, input dig_idx_t idx);
    logic hide;
    hide = (idx != 2'd0);
    for (int k = 1; k < NUM_DIGITS; k++) begin
      if (dig_idx_t'(k) >= idx && nibble_sel(num, dig_idx_t'(k)) != 4'h0) hide = 1'b0;
    end
    return hide;
  endfunction

endpackage

// File: rtl/digit_scanner_scan_timer.sv
// rtl/digit_scanner_scan_timer.sv - digit slot counter, digit index, frame tick and blank window
module scan_timer
  import display_pkg::*;
#(
  parameter int SCAN_DIV  = 12500,
  parameter int BLANK_CYC = 250
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [3:0] dig,
  output logic       frame_tick,
  output dig_idx_t   idx_nxt,
  output logic       blank_nxt
);

  localparam int               CNT_W     = $clog2(SCAN_DIV);
  localparam logic [CNT_W-1:0] LAST      = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_END = CNT_W'(BLANK_CYC);

  logic [CNT_W-1:0] slot_cnt;
  logic [CNT_W-1:0] cnt_nxt;
  dig_idx_t         idx;
  logic             wrap;
  logic             tick_nxt;

  // Next-state values are exported so the anode register lines up with the slot it drives.
  always_comb begin
    wrap      = (slot_cnt == LAST);
    cnt_nxt   = wrap ? '0 : slot_cnt + CNT_W'(1);
    idx_nxt   = wrap ? idx + 2'd1 : idx;
    blank_nxt = (cnt_nxt < BLANK_END);
    tick_nxt  = (cnt_nxt == LAST) && (idx_nxt == 2'd3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt   <= '0;
      idx        <= 2'd0;
      dig        <= DIG0;
      frame_tick <= 1'b0;
    end else begin
      slot_cnt   <= cnt_nxt;
      idx        <= idx_nxt;
      dig        <= dig_onehot(idx_nxt);
      frame_tick <= tick_nxt;
    end
  end

endmodule

// File: rtl/digit_scanner.sv
// rtl/digit_scanner.sv - 4-digit multiplexed 7-segment scanner with frame-aligned value updates
module digit_scanner
  import display_pkg::*;
#(
  parameter int SCAN_DIV  = 12500,
  parameter int BLANK_CYC = 250,
  parameter int LZ_BLANK  = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] num_in,
  input  logic        num_valid,
  output logic        num_ready,
  output logic [15:0] number,
  output logic [3:0]  dig,
  output logic [3:0]  dig_en_n,
  output logic        frame_tick
);

  dig_idx_t    idx_nxt;
  logic        blank_nxt;
  logic        accept;
  logic        apply;
  logic        hide_nxt;
  logic [15:0] shadow;
  logic [15:0] number_nxt;

  scan_timer #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_scan_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .dig        (dig),
    .frame_tick (frame_tick),
    .idx_nxt    (idx_nxt),
    .blank_nxt  (blank_nxt)
  );

  // num_ready doubles as ~pending; accept and apply can never coincide.
  always_comb begin
    accept     = num_valid & num_ready;
    apply      = frame_tick & ~num_ready;
    number_nxt = apply ? shadow : number;
    hide_nxt   = (LZ_BLANK != 0) && lead_zero(number_nxt, idx_nxt);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      number    <= '0;
      shadow    <= '0;
      num_ready <= 1'b1;
      dig_en_n  <= ANODES_OFF;
    end else begin
      number <= number_nxt;
      if (accept) begin
        shadow    <= num_in;
        num_ready <= 1'b0;
      end else if (apply) begin
        num_ready <= 1'b1;
      end
      dig_en_n <= (blank_nxt || hide_nxt) ? ANODES_OFF : ~dig_onehot(idx_nxt);
    end
  end

endmodule

// File: tb/tb_digit_scanner.sv
// tb/tb_digit_scanner.sv - scoreboard bench for digit_scanner (plain and leading-zero instances)
module tb_digit_scanner;

  localparam int SD = 8;
  localparam int BC = 2;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] num_in     [2];
  logic        num_valid  [2];
  logic        num_ready  [2];
  logic [15:0] number     [2];
  logic [3:0]  dig        [2];
  logic [3:0]  dig_en_n   [2];
  logic        frame_tick [2];

  int checks   = 0;
  int failures = 0;

  digit_scanner #(.SCAN_DIV(SD), .BLANK_CYC(BC), .LZ_BLANK(0)) dut (
    .clk(clk), .rst_n(rst_n), .num_in(num_in[0]), .num_valid(num_valid[0]),
    .num_ready(num_ready[0]), .number(number[0]), .dig(dig[0]),
    .dig_en_n(dig_en_n[0]), .frame_tick(frame_tick[0]));

  digit_scanner #(.SCAN_DIV(SD), .BLANK_CYC(BC), .LZ_BLANK(1)) dut_lz (
    .clk(clk), .rst_n(rst_n), .num_in(num_in[1]), .num_valid(num_valid[1]),
    .num_ready(num_ready[1]), .number(number[1]), .dig(dig[1]),
    .dig_en_n(dig_en_n[1]), .frame_tick(frame_tick[1]));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int inst, input logic [15:0] act, input logic [15:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s inst=%0d t=%0t act=%h exp=%h", name, inst, $time, act, exp_v);
    end
  endtask

  // Reference timing model and expected-value queues, advanced on the DUT clock.
  int          m_cnt = 0;
  int          m_idx = 0;
  bit          m_tick;
  bit          m_pend    [2];
  bit          m_applied [2];
  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] prev_num [2];
  logic [15:0] exp_cur  [2];

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt = 0;
      m_idx = 0;
      for (int i = 0; i < 2; i++) begin
        m_pend[i]    = 1'b0;
        m_applied[i] = 1'b0;
        prev_num[i]  = 16'h0;
        exp_cur[i]   = 16'h0;
      end
      q0.delete();
      q1.delete();
    end else begin
      m_tick = (m_idx == 3) && (m_cnt == SD - 1);
      for (int i = 0; i < 2; i++) begin
        m_applied[i] = m_tick && m_pend[i];
        if (num_valid[i] && !m_pend[i]) begin
          m_pend[i] = 1'b1;
          if (i == 0) q0.push_back(num_in[i]);
          else        q1.push_back(num_in[i]);
        end else if (m_applied[i]) begin
          m_pend[i] = 1'b0;
        end
      end
      if (m_cnt == SD - 1) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 4;
      end else begin
        m_cnt++;
      end
    end
  end

  logic [15:0] e_val;
  bit          have;
  bit          hide;
  logic [3:0]  exp_dig;
  logic [3:0]  exp_en;

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (m_applied[i] || number[i] !== prev_num[i]) begin
        have = 1'b0;
        if (i == 0 && q0.size() > 0) begin e_val = q0.pop_front(); have = 1'b1; end
        if (i == 1 && q1.size() > 0) begin e_val = q1.pop_front(); have = 1'b1; end
        checks++;
        if (!have) begin
          failures++;
          $display("FAIL number_unexpected inst=%0d t=%0t act=%h exp=%h", i, $time, number[i], prev_num[i]);
        end else begin
          exp_cur[i] = e_val;
          if (!m_applied[i] || number[i] !== e_val) begin
            failures++;
            $display("FAIL number_update inst=%0d t=%0t act=%h exp=%h boundary=%0d",
                     i, $time, number[i], e_val, m_applied[i]);
          end
        end
        prev_num[i] = number[i];
      end
      exp_dig = 4'b0001 << m_idx;
      hide    = (i == 1) && (m_idx > 0) && ((exp_cur[i] >> (4 * m_idx)) == 16'h0);
      exp_en  = (m_cnt < BC || hide) ? 4'b1111 : ~exp_dig;
      chk("dig", i, {12'h0, dig[i]}, {12'h0, exp_dig});
      chk("dig_en_n", i, {12'h0, dig_en_n[i]}, {12'h0, exp_en});
      chk("frame_tick", i, {15'h0, frame_tick[i]}, {15'h0, m_tick_now()});
      chk("num_ready", i, {15'h0, num_ready[i]}, {15'h0, !m_pend[i]});
    end
  end

  function automatic logic m_tick_now();
    return (m_idx == 3) && (m_cnt == SD - 1);
  endfunction

  task automatic wait_slot(input int idx, input int cnt);
    int n = 0;
    while (!(m_idx == idx && m_cnt == cnt) && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL wait_slot_timeout idx=%0d cnt=%0d act=%0d/%0d", idx, cnt, m_idx, m_cnt);
    end
  endtask

  task automatic wait_ready(input int inst);
    int n = 0;
    while (num_ready[inst] !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 200) begin
      failures++;
      $display("FAIL wait_ready_timeout inst=%0d act=%b exp=1", inst, num_ready[inst]);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    for (int i = 0; i < 2; i++) begin
      chk({tag, "_number"}, i, number[i], 16'h0000);
      chk({tag, "_dig"}, i, {12'h0, dig[i]}, 16'h0001);
      chk({tag, "_dig_en_n"}, i, {12'h0, dig_en_n[i]}, 16'h000f);
      chk({tag, "_num_ready"}, i, {15'h0, num_ready[i]}, 16'h0001);
      chk({tag, "_frame_tick"}, i, {15'h0, frame_tick[i]}, 16'h0000);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      num_in[i]    = 16'h0;
      num_valid[i] = 1'b0;
    end
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // Single-cycle transfer at cycle 5; leading-zero instance gets 0105 at the same time.
    wait_slot(0, 5);
    num_in[0] = 16'h1234; num_valid[0] = 1'b1;
    num_in[1] = 16'h0105; num_valid[1] = 1'b1;
    @(negedge clk);
    num_valid[0] = 1'b0; num_valid[1] = 1'b0;
    chk("ready_low_after_accept", 0, {15'h0, num_ready[0]}, 16'h0000);
    wait_ready(0);
    chk("number_after_frame", 0, number[0], 16'h1234);

    // Held valid: ABCD accepted, source changes to 5678 while stalled, 5678 taken when ready returns.
    wait_slot(1, 2);
    num_in[0] = 16'hABCD; num_valid[0] = 1'b1;
    repeat (4) @(negedge clk);
    num_in[0] = 16'h5678;
    wait_ready(0);
    chk("held_first_value", 0, number[0], 16'hABCD);
    @(negedge clk);
    num_valid[0] = 1'b0;
    chk("held_second_accepted", 0, {15'h0, num_ready[0]}, 16'h0000);
    wait_ready(0);
    chk("held_second_value", 0, number[0], 16'h5678);

    // Transfer on the frame_tick cycle itself lands one frame later.
    wait_slot(3, SD - 1);
    num_in[0] = 16'h9999; num_valid[0] = 1'b1;
    @(negedge clk);
    num_valid[0] = 1'b0;
    chk("tick_transfer_deferred", 0, number[0], 16'h5678);
    wait_ready(0);
    chk("tick_transfer_value", 0, number[0], 16'h9999);

    // Reset mid-slot with a value pending; shadow must be discarded.
    wait_slot(1, 3);
    num_in[0] = 16'h4321; num_valid[0] = 1'b1;
    @(negedge clk);
    num_valid[0] = 1'b0;
    wait_slot(2, 4);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (100) @(negedge clk);
    chk("no_stale_shadow", 0, number[0], 16'h0000);
    checks++;
    if (q0.size() != 0 || q1.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain act=%0d/%0d exp=0/0", q0.size(), q1.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
